// File: rtl/radar_signal_conditioner.sv
// rtl/radar_signal_conditioner.sv - radar line synchroniser, glitch filter, edge pulser and USEC tick
//
// Purpose: conditions the asynchronous ARP/ACP/TRIG radar lines into single-cycle
// rising-edge strobes, generates a free-running microsecond tick and counts
// rejected (too short) input transitions.
//
// Ports:
//   S_AXIS_ACLK     PL system clock
//   S_AXIS_ARESETN  asynchronous active-low reset
//   ARP_IN/ACP_IN/TRIG_IN  raw asynchronous radar lines
//   GLITCH_CLR      synchronous clear of GLITCH_CNT (wins over increments)
//   ARP/ACP/TRIG    one-cycle pulse on accepted rising edge
//   USEC            one-cycle tick every USEC_DIV cycles
//   GLITCH_CNT      saturating count of rejected transitions
module radar_signal_conditioner #(
   parameter int         USEC_DIV   = 100,
   parameter int         FILTER_LEN = 4,
   parameter logic [2:0] ACTIVE_LOW = 3'b000,
   parameter int         GLITCH_W   = 16
) (
   input  logic                S_AXIS_ACLK,
   input  logic                S_AXIS_ARESETN,
   input  logic                ARP_IN,
   input  logic                ACP_IN,
   input  logic                TRIG_IN,
   input  logic                GLITCH_CLR,
   output logic                ARP,
   output logic                ACP,
   output logic                TRIG,
   output logic                USEC,
   output logic [GLITCH_W-1:0] GLITCH_CNT
);

   localparam int FC_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int DIV_W = $clog2(USEC_DIV);
   localparam logic [FC_W-1:0]     FC_LAST    = FC_W'(FILTER_LEN - 1);
   localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(USEC_DIV - 1);
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

   // Channel index: 0 ARP, 1 ACP, 2 TRIG
   logic [2:0]            raw_lvl;
   logic [2:0]            sync1_q;
   logic [2:0]            sync2_q;
   logic [2:0]            lvl_q, lvl_d;
   logic [2:0][FC_W-1:0]  fcnt_q, fcnt_d;
   logic [2:0]            pulse_q, pulse_d;
   logic [2:0]            glitch;
   logic [1:0]            n_glitch;
   logic [DIV_W-1:0]      div_q, div_d;
   logic                  usec_q, usec_d;
   logic [GLITCH_W:0]     gsum;
   logic [GLITCH_W-1:0]   gcnt_q, gcnt_d;

   // Polarity is normalised before the synchroniser so everything downstream is logical level
   assign raw_lvl = {TRIG_IN, ACP_IN, ARP_IN} ^ ACTIVE_LOW;

   // A level is accepted only after it has differed from the accepted level for
   // FILTER_LEN consecutive cycles; a run that ends early is counted as a glitch.
   always_comb begin
      lvl_d   = lvl_q;
      fcnt_d  = fcnt_q;
      pulse_d = '0;
      glitch  = '0;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != lvl_q[i]) begin
            if (fcnt_q[i] == FC_LAST) begin
               lvl_d[i]   = sync2_q[i];
               fcnt_d[i]  = '0;
               pulse_d[i] = sync2_q[i];
            end else begin
               fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
         end else if (fcnt_q[i] != '0) begin
            fcnt_d[i] = '0;
            glitch[i] = 1'b1;
         end
      end
   end

   // Up to three glitches may land in one cycle; the extra sum bit detects saturation
   always_comb begin
      n_glitch = {1'b0, glitch[0]} + {1'b0, glitch[1]} + {1'b0, glitch[2]};
      gsum     = {1'b0, gcnt_q} + (GLITCH_W + 1)'(n_glitch);
      if (GLITCH_CLR) begin
         gcnt_d = '0;
      end else if (gsum[GLITCH_W]) begin
         gcnt_d = GLITCH_MAX;
      end else begin
         gcnt_d = gsum[GLITCH_W-1:0];
      end
   end

   always_comb begin
      usec_d = (div_q == DIV_LAST);
      div_d  = usec_d ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         fcnt_q  <= '0;
         pulse_q <= '0;
         div_q   <= '0;
         usec_q  <= 1'b0;
         gcnt_q  <= '0;
      end else begin
         sync1_q <= raw_lvl;
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         fcnt_q  <= fcnt_d;
         pulse_q <= pulse_d;
         div_q   <= div_d;
         usec_q  <= usec_d;
         gcnt_q  <= gcnt_d;
      end
   end

   assign ARP        = pulse_q[0];
   assign ACP        = pulse_q[1];
   assign TRIG       = pulse_q[2];
   assign USEC       = usec_q;
   assign GLITCH_CNT = gcnt_q;

endmodule

// File: tb/tb_radar_signal_conditioner.sv
// tb/tb_radar_signal_conditioner.sv - scoreboard bench for radar_signal_conditioner
module tb_radar_signal_conditioner;

   typedef struct {
      int ch;
      int tgt;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        arp_in, acp_in, trig_in, gclr;
   logic        arp, acp, trig, usec;
   logic [15:0] gcnt;
   logic        al_trig_in;
   logic        al_arp, al_acp, al_trig, al_usec;
   logic [15:0] al_gcnt;

   int   cyc;
   int   n_checks;
   int   n_fail;
   int   k;
   exp_t sb_q[$];

   radar_signal_conditioner #(
      .USEC_DIV(100), .FILTER_LEN(4), .ACTIVE_LOW(3'b000), .GLITCH_W(16)
   ) dut (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
      .ARP_IN(arp_in), .ACP_IN(acp_in), .TRIG_IN(trig_in), .GLITCH_CLR(gclr),
      .ARP(arp), .ACP(acp), .TRIG(trig), .USEC(usec), .GLITCH_CNT(gcnt)
   );

   radar_signal_conditioner #(
      .USEC_DIV(100), .FILTER_LEN(4), .ACTIVE_LOW(3'b100), .GLITCH_W(16)
   ) dut_al (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
      .ARP_IN(1'b0), .ACP_IN(1'b0), .TRIG_IN(al_trig_in), .GLITCH_CLR(1'b0),
      .ARP(al_arp), .ACP(al_acp), .TRIG(al_trig), .USEC(al_usec), .GLITCH_CNT(al_gcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since the latest reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic push_exp(input int ch, input int tgt);
      exp_t e;
      e.ch  = ch;
      e.tgt = tgt;
      sb_q.push_back(e);
   endtask

   // Scoreboard consumer: channels 0..2 main instance, 3..5 active-low instance
   always @(negedge clk) begin : mon
      logic [5:0] outs;
      int         idx;
      if (rst_n) begin
         outs = {al_trig, al_acp, al_arp, trig, acp, arp};
         for (int ch = 0; ch < 6; ch++) begin
            if (outs[ch]) begin
               idx = -1;
               for (int i = 0; i < sb_q.size(); i++)
                  if (idx < 0 && sb_q[i].ch == ch) idx = i;
               if (idx < 0) begin
                  check_eq($sformatf("spurious_pulse_ch%0d", ch), cyc, 0);
               end else begin
                  check_eq($sformatf("pulse_cycle_ch%0d", ch), cyc, sb_q[idx].tgt);
                  sb_q.delete(idx);
               end
            end
         end
         check_eq("usec", usec, (cyc != 0 && cyc % 100 == 0));
         check_eq("usec_al", al_usec, (cyc != 0 && cyc % 100 == 0));
      end
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      arp_in     = 1'b0;
      acp_in     = 1'b0;
      trig_in    = 1'b0;
      gclr       = 1'b0;
      al_trig_in = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset_outputs", {arp, acp, trig, usec, gcnt}, 0);
      check_eq("reset_outputs_al", {al_arp, al_acp, al_trig, al_usec, al_gcnt}, 0);
      rst_n = 1'b1;

      // 1: idle run, only USEC activity
      repeat (1000) @(negedge clk);
      check_eq("idle_glitch", gcnt, 0);

      // 2: clean ACP pulse, no pulse on fall
      acp_in = 1'b1;
      k = cyc + 1;
      push_exp(1, k + 5);
      repeat (10) @(negedge clk);
      acp_in = 1'b0;
      repeat (15) @(negedge clk);
      check_eq("acp_glitch", gcnt, 0);
      check_eq("acp_sb_empty", sb_q.size(), 0);

      // 3: short TRIG rejected, 4-cycle TRIG accepted
      trig_in = 1'b1;
      repeat (3) @(negedge clk);
      trig_in = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("trig_short_glitch", gcnt, 1);
      trig_in = 1'b1;
      k = cyc + 1;
      push_exp(2, k + 5);
      repeat (4) @(negedge clk);
      trig_in = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("trig_ok_glitch", gcnt, 1);
      check_eq("trig_sb_empty", sb_q.size(), 0);

      // 4: simultaneous glitches, clear priority, saturation
      arp_in = 1'b1;
      acp_in = 1'b1;
      k = cyc + 1;
      repeat (2) @(negedge clk);
      arp_in = 1'b0;
      acp_in = 1'b0;
      wait_cyc(k + 3);
      check_eq("dual_glitch_before", gcnt, 1);
      @(negedge clk);
      check_eq("dual_glitch_after", gcnt, 3);
      repeat (6) @(negedge clk);
      arp_in = 1'b1;
      acp_in = 1'b1;
      k = cyc + 1;
      repeat (2) @(negedge clk);
      arp_in = 1'b0;
      acp_in = 1'b0;
      wait_cyc(k + 3);
      check_eq("clr_before", gcnt, 3);
      gclr = 1'b1;
      @(negedge clk);
      gclr = 1'b0;
      check_eq("clr_priority", gcnt, 0);
      repeat (6) @(negedge clk);
      for (int n = 0; n < 21844; n++) begin
         {trig_in, acp_in, arp_in} = 3'b111;
         @(negedge clk);
         {trig_in, acp_in, arp_in} = 3'b000;
         @(negedge clk);
      end
      {acp_in, arp_in} = 2'b11;
      @(negedge clk);
      {acp_in, arp_in} = 2'b00;
      repeat (6) @(negedge clk);
      check_eq("preload_65534", gcnt, 65534);
      for (int n = 0; n < 2; n++) begin
         {trig_in, acp_in, arp_in} = 3'b111;
         @(negedge clk);
         {trig_in, acp_in, arp_in} = 3'b000;
         repeat (6) @(negedge clk);
         check_eq($sformatf("saturate_%0d", n), gcnt, 65535);
      end

      // 5: active-low TRIG
      al_trig_in = 1'b0;
      k = cyc + 1;
      push_exp(5, k + 5);
      repeat (6) @(negedge clk);
      al_trig_in = 1'b1;
      repeat (12) @(negedge clk);
      check_eq("al_sb_empty", sb_q.size(), 0);
      check_eq("al_glitch", al_gcnt, 0);

      // 6: asynchronous reset mid-filter
      arp_in = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_reset_outputs", {arp, acp, trig, usec, gcnt}, 0);
      check_eq("async_reset_outputs_al", {al_arp, al_acp, al_trig, al_usec, al_gcnt}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(0, 6);
      repeat (110) @(negedge clk);
      check_eq("post_reset_sb_empty", sb_q.size(), 0);
      check_eq("post_reset_glitch", gcnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
